iob_mem_arbiter: RTL
====================

Name: iob_mem_arbiter

Overview:
- Two-requester arbiter that shares one native memory port between the CPU instruction bus (requester 0) and data bus (requester 1).
- Sits between the VexRiscv wrapper's ibus/dbus request/response pairs and a single-ported SRAM/boot memory or interconnect slave.
- Allows one outstanding transaction at a time.
- Supports round-robin or fixed data-priority arbitration, with a registered grant.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; strobe width is DATA_W/8
DBUS_PRIO, 0, 0 = round-robin between requesters; 1 = requester 1 (dbus) always wins ties

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (rst=0 resets on next clk edge)
i_valid  in  1  ibus request valid, held until i_ready
i_addr  in  ADDR_W  ibus address
i_wdata  in  DATA_W  ibus write data (normally 0)
i_wstrb  in  DATA_W/8  ibus write strobe; 0 = read
i_ready  out  1  ibus response pulse, 1 cycle
i_rdata  out  DATA_W  ibus read data, valid when i_ready=1
d_valid  in  1  dbus request valid, held until d_ready
d_addr  in  ADDR_W  dbus address
d_wdata  in  DATA_W  dbus write data
d_wstrb  in  DATA_W/8  dbus write strobe; 0 = read
d_ready  out  1  dbus response pulse, 1 cycle
d_rdata  out  DATA_W  dbus read data, valid when d_ready=1
m_valid  out  1  memory request valid
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_wstrb  out  DATA_W/8  memory write strobe
m_ready  in  1  memory response pulse
m_rdata  in  DATA_W  memory read data
busy  out  1  transaction outstanding
grant  out  1  requester owning the port (0 = ibus, 1 = dbus); meaningful when busy=1

Behaviour:
- Requester protocol:
  - valid rises with addr/wdata/wstrb and holds them stable until the matching ready pulse.
  - In the cycle after its ready, the requester deasserts valid or presents a new request.
- States are IDLE and BUSY, held in a state register plus a grant register and a last-served register (last).
- Reset (rst=0 at edge): state=IDLE, grant=0, last=1 (ibus wins the first round-robin tie), busy=0, m_valid=0, i_ready=0, d_ready=0.
  - Reset mid-transaction aborts it. Any later m_ready pulse is ignored and not forwarded.
- IDLE:
  - If neither valid is set, remain in IDLE.
  - If only one valid is set, grant that requester.
  - If both are set:
    - DBUS_PRIO=1: grant 1.
    - DBUS_PRIO=0: grant the requester not equal to last.
  - The grant is registered, and state->BUSY at the same edge.
  - Arbitration latency: request valid at cycle t gives m_valid=1 at cycle t+1.
- BUSY:
  - m_valid=1.
  - m_addr/m_wdata/m_wstrb are driven combinationally from the granted requester's inputs.
  - When idle, m_addr/m_wdata/m_wstrb=0.
  - m_ready is routed to exactly one of i_ready/d_ready, per grant, in the same cycle (combinational).
  - m_rdata is routed to both i_rdata and d_rdata; only the one with ready=1 is meaningful.
  - On m_ready=1:
    - last<=grant.
    - state->IDLE at the next edge.
    - m_valid drops next cycle.
    - Minimum one idle cycle between transactions; throughput is at most one transaction per 2 cycles plus memory latency.
  - m_ready=1 while IDLE is ignored: no ready is forwarded.
  - A requester dropping valid while granted is a protocol violation. The arbiter stays BUSY until m_ready regardless.
- Zero-latency memory: m_ready may be 1 in the first BUSY cycle, giving ready at t+1.
- busy=(state==BUSY); grant holds its value after return to IDLE.

Test Plan:
- ibus-only read: i_valid=1, i_addr=0x100 at t0; memory returns m_ready=1, m_rdata=0xDEADBEEF at t2 -> m_valid=1 and m_addr=0x100 at t1..t2, i_ready=1 and i_rdata=0xDEADBEEF at t2, d_ready=0, busy=0 at t3.
- dbus write: d_addr=0x2004, d_wdata=0x12345678, d_wstrb=0xF -> m_wstrb=0xF, m_wdata=0x12345678, grant=1, d_ready pulses only with m_ready.
- Simultaneous requests, DBUS_PRIO=0, both valid continuously after reset -> grants alternate 0,1,0,1; no starvation over 8 transactions.
- Simultaneous requests, DBUS_PRIO=1 -> dbus served first each time both are pending; ibus served only when d_valid=0.
- Reset mid-transaction: rst=0 during BUSY, m_ready=1 one cycle after reset -> busy=0, m_valid=0, i_ready=d_ready=0 throughout.
- Stray m_ready=1 in IDLE -> no i_ready/d_ready pulse, state unchanged.

Source files
------------

// File: rtl/iob_mem_arbiter.sv
// Two-requester arbiter sharing one native memory port between the CPU
// instruction bus (requester 0) and data bus (requester 1); one transaction in flight.
module iob_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DBUS_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  output logic                  i_ready,
  output logic [DATA_W-1:0]     i_rdata,

  input  logic                  d_valid,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_rdata,

  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_ready,
  input  logic [DATA_W-1:0]     m_rdata,

  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  logic   last;
  logic   next_grant;

  // Ties go to dbus when prioritised, otherwise to whoever was not served last.
  always_comb begin
    next_grant = d_valid;
    if (i_valid && d_valid)
      next_grant = (DBUS_PRIO != 0) ? 1'b1 : ~last;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid || d_valid) begin
            state <= BUSY;
            grant <= next_grant;
          end
        end
        BUSY: begin
          if (m_ready) begin
            state <= IDLE;
            last  <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == BUSY);
  assign m_valid = busy;

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    if (busy) begin
      if (grant) begin
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wstrb = d_wstrb;
      end else begin
        m_addr  = i_addr;
        m_wdata = i_wdata;
        m_wstrb = i_wstrb;
      end
    end
  end

  // m_ready outside BUSY is a stray pulse and is never forwarded.
  assign i_ready = busy && m_ready && !grant;
  assign d_ready = busy && m_ready &&  grant;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule
